// File: rtl/gem_tx_link_ctrl.sv
// rtl/gem_tx_link_ctrl.sv - GEM trigger-fiber TX link bring-up sequencer; GEM_TX_UPTIME_EN builds the UPTIME counter
module gem_tx_link_ctrl #(
    parameter int COMMA_CYCLES = 256,
    parameter int PRBS_CYCLES  = 4096,
    parameter int LOCK_FILTER  = 8
) (
    input  logic        TRG_CLK80,
    input  logic        TRG_TXRESETDONE,
    input  logic        TRG_TX_PLL_LOCK,
    input  logic        TX_SYNC_DONE,
    input  logic        TX_SEL,
    input  logic        FORCE_PRBS,
    input  logic        REQ_RESYNC,
    output logic        TRG_RST,
    output logic        ENA_TEST_PAT,
    output logic        LINK_UP,
    output logic [1:0]  LINK_STATE,
    output logic [7:0]  LOL_CNT,
    output logic [31:0] UPTIME
);

    localparam int CNT_MAX = (COMMA_CYCLES > PRBS_CYCLES) ? COMMA_CYCLES : PRBS_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FLT_W   = $clog2(LOCK_FILTER + 1);

    localparam logic [CNT_W-1:0] COMMA_LAST = CNT_W'(COMMA_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRBS_LAST  = CNT_W'((PRBS_CYCLES > 0) ? PRBS_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] PRBS_FULL  = CNT_W'(PRBS_CYCLES);
    localparam logic [FLT_W-1:0] FLT_LAST   = FLT_W'(LOCK_FILTER - 1);

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_COMMA     = 2'd1,
        ST_PRBS      = 2'd2,
        ST_DATA      = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [FLT_W-1:0] flt_q, flt_d;
    logic [7:0]       lol_q, lol_d;
    logic             trg_rst_q, trg_rst_d;
    logic             ena_q, ena_d;
    logic             link_up_q, link_up_d;
    logic             lock_meta_q, lock_sync_q;
    logic             lock_ok;
    logic             prbs_expired;

    assign lock_ok      = lock_sync_q & TX_SYNC_DONE;
    assign prbs_expired = (cyc_q == PRBS_LAST) || (cyc_q == PRBS_FULL);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        flt_d   = flt_q;
        lol_d   = lol_q;
        case (state_q)
            ST_WAIT_SYNC: begin
                if (!lock_ok) begin
                    flt_d = '0;
                end else if (flt_q == FLT_LAST) begin
                    state_d = ST_COMMA;
                    flt_d   = '0;
                    cyc_d   = '0;
                end else begin
                    flt_d = flt_q + 1'b1;
                end
            end
            ST_COMMA: begin
                if (cyc_q == COMMA_LAST) begin
                    state_d = (PRBS_CYCLES == 0) ? ST_DATA : ST_PRBS;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_PRBS: begin
                // Hand over only on a frame boundary so no frame mixes PRBS and data.
                if (REQ_RESYNC) begin
                    state_d = ST_COMMA;
                    cyc_d   = '0;
                end else if (prbs_expired && !TX_SEL) begin
                    state_d = ST_DATA;
                    cyc_d   = '0;
                end else if (cyc_q != PRBS_FULL) begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin
                if (REQ_RESYNC) begin
                    state_d = ST_COMMA;
                    cyc_d   = '0;
                end
            end
        endcase
        if (state_q != ST_WAIT_SYNC && !lock_ok) begin
            state_d = ST_WAIT_SYNC;
            cyc_d   = '0;
            flt_d   = '0;
            if (lol_q != 8'hFF) begin
                lol_d = lol_q + 8'd1;
            end
        end
    end

    always_comb begin
        trg_rst_d = (state_d == ST_WAIT_SYNC) || (state_d == ST_COMMA);
        link_up_d = (state_d == ST_DATA);
        ena_d     = 1'b0;
        if (state_d == ST_PRBS) begin
            ena_d = 1'b1;
        end else if (state_d == ST_DATA) begin
            if (!TX_SEL) begin
                ena_d = FORCE_PRBS;
            end else if (state_q == ST_DATA) begin
                ena_d = ena_q;
            end
        end
    end

    always_ff @(posedge TRG_CLK80 or negedge TRG_TXRESETDONE) begin
        if (!TRG_TXRESETDONE) begin
            state_q     <= ST_WAIT_SYNC;
            cyc_q       <= '0;
            flt_q       <= '0;
            lol_q       <= '0;
            trg_rst_q   <= 1'b1;
            ena_q       <= 1'b0;
            link_up_q   <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            flt_q       <= flt_d;
            lol_q       <= lol_d;
            trg_rst_q   <= trg_rst_d;
            ena_q       <= ena_d;
            link_up_q   <= link_up_d;
            lock_meta_q <= TRG_TX_PLL_LOCK;
            lock_sync_q <= lock_meta_q;
        end
    end

    assign TRG_RST      = trg_rst_q;
    assign ENA_TEST_PAT = ena_q;
    assign LINK_UP      = link_up_q;
    assign LINK_STATE   = state_q;
    assign LOL_CNT      = lol_q;

`ifdef GEM_TX_UPTIME_EN
    logic [31:0] uptime_q, uptime_d;

    always_comb begin
        uptime_d = 32'd0;
        if (state_d == ST_DATA && state_q == ST_DATA) begin
            uptime_d = (uptime_q == 32'hFFFF_FFFF) ? uptime_q : uptime_q + 32'd1;
        end
    end

    always_ff @(posedge TRG_CLK80 or negedge TRG_TXRESETDONE) begin
        if (!TRG_TXRESETDONE) begin
            uptime_q <= 32'd0;
        end else begin
            uptime_q <= uptime_d;
        end
    end

    assign UPTIME = uptime_q;
`else
    assign UPTIME = 32'd0;
`endif

endmodule

// File: tb/tb_gem_tx_link_ctrl.sv
// tb/tb_gem_tx_link_ctrl.sv - directed bench for gem_tx_link_ctrl with PRBS_CYCLES=8 and PRBS_CYCLES=0 instances
module tb_gem_tx_link_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        pll_lock = 1'b1;
    logic        sync_done = 1'b1;
    logic        tx_sel = 1'b0;
    logic        force_prbs = 1'b0;
    logic        req_resync = 1'b0;
    logic        sel_at_edge = 1'b0;

    logic        trg_rst, ena, link_up;
    logic [1:0]  state;
    logic [7:0]  lol;
    logic [31:0] uptime;

    logic        trg_rst0, ena0, link_up0;
    logic [1:0]  state0;
    logic [7:0]  lol0;
    logic [31:0] uptime0;

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    gem_tx_link_ctrl #(.COMMA_CYCLES(4), .PRBS_CYCLES(8), .LOCK_FILTER(3)) dut (
        .TRG_CLK80(clk), .TRG_TXRESETDONE(resetn), .TRG_TX_PLL_LOCK(pll_lock),
        .TX_SYNC_DONE(sync_done), .TX_SEL(tx_sel), .FORCE_PRBS(force_prbs),
        .REQ_RESYNC(req_resync), .TRG_RST(trg_rst), .ENA_TEST_PAT(ena),
        .LINK_UP(link_up), .LINK_STATE(state), .LOL_CNT(lol), .UPTIME(uptime)
    );

    gem_tx_link_ctrl #(.COMMA_CYCLES(4), .PRBS_CYCLES(0), .LOCK_FILTER(3)) dut0 (
        .TRG_CLK80(clk), .TRG_TXRESETDONE(resetn), .TRG_TX_PLL_LOCK(pll_lock),
        .TX_SYNC_DONE(sync_done), .TX_SEL(tx_sel), .FORCE_PRBS(force_prbs),
        .REQ_RESYNC(req_resync), .TRG_RST(trg_rst0), .ENA_TEST_PAT(ena0),
        .LINK_UP(link_up0), .LINK_STATE(state0), .LOL_CNT(lol0), .UPTIME(uptime0)
    );

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        sel_at_edge = tx_sel;
        #1;
        tx_sel = ~tx_sel;
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        pll_lock   = 1'b1;
        sync_done  = 1'b1;
        force_prbs = 1'b0;
        req_resync = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic wait_data();
        int n = 0;
        while (link_up !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        asserts++;
        if (link_up !== 1'b1) begin
            fails++;
            $display("FAIL wait_data: LINK_UP=%b after %0d cycles, required 1", link_up, n);
        end
    endtask

    task automatic bring_up();
        do_reset();
        wait_data();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        asserts++; if (state !== 2'd0)   begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
        asserts++; if (trg_rst !== 1'b1) begin fails++; $display("FAIL reset_trg_rst: got %b want 1", trg_rst); end
        asserts++; if (ena !== 1'b0)     begin fails++; $display("FAIL reset_ena: got %b want 0", ena); end
        asserts++; if (link_up !== 1'b0) begin fails++; $display("FAIL reset_link_up: got %b want 0", link_up); end
        asserts++; if (lol !== 8'd0)     begin fails++; $display("FAIL reset_lol: got %0d want 0", lol); end
        asserts++; if (uptime !== 32'd0) begin fails++; $display("FAIL reset_uptime: got %0d want 0", uptime); end
    endtask

    task automatic test_bringup();
        int n = 0;
        do_reset();
        repeat (4) tick();
        asserts++; if (state !== 2'd0) begin fails++; $display("FAIL bringup_filter: state %0d at edge 4, want 0", state); end
        tick();
        asserts++; if (state !== 2'd1) begin fails++; $display("FAIL bringup_comma: state %0d at edge 5, want 1", state); end
        asserts++; if (trg_rst !== 1'b1) begin fails++; $display("FAIL bringup_comma_rst: TRG_RST %b want 1", trg_rst); end
        repeat (3) tick();
        asserts++; if (state !== 2'd1 || trg_rst !== 1'b1) begin fails++; $display("FAIL bringup_comma_hold: state %0d rst %b want 1/1", state, trg_rst); end
        tick();
        asserts++; if (state !== 2'd2) begin fails++; $display("FAIL bringup_prbs: state %0d at edge 9, want 2", state); end
        asserts++; if (trg_rst !== 1'b0 || ena !== 1'b1) begin fails++; $display("FAIL bringup_prbs_out: rst %b ena %b want 0/1", trg_rst, ena); end
        while (link_up !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        asserts++; if (n != 8 && n != 9) begin fails++; $display("FAIL bringup_prbs_len: %0d cycles, want 8 or 9", n); end
        asserts++; if (sel_at_edge !== 1'b0) begin fails++; $display("FAIL bringup_frame_edge: TX_SEL at handover %b want 0", sel_at_edge); end
        asserts++; if (state !== 2'd3 || ena !== 1'b0 || trg_rst !== 1'b0) begin
            fails++; $display("FAIL bringup_data: state %0d ena %b rst %b want 3/0/0", state, ena, trg_rst);
        end
    endtask

    task automatic test_no_prbs();
        logic saw_ena = 1'b0;
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (ena0 === 1'b1) saw_ena = 1'b1;
            if (i == 8) begin
                asserts++; if (state0 !== 2'd1) begin fails++; $display("FAIL noprbs_comma: state %0d at edge 8 want 1", state0); end
            end
            if (i == 9) begin
                asserts++; if (state0 !== 2'd3 || link_up0 !== 1'b1 || trg_rst0 !== 1'b0) begin
                    fails++; $display("FAIL noprbs_data: state %0d up %b rst %b want 3/1/0", state0, link_up0, trg_rst0);
                end
            end
        end
        asserts++; if (saw_ena !== 1'b0) begin fails++; $display("FAIL noprbs_ena: ENA_TEST_PAT asserted %b want 0", saw_ena); end
    endtask

    task automatic test_loss_of_lock();
        int tmo = 0;
        int n;
        bring_up();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        asserts++; if (state !== 2'd3) begin fails++; $display("FAIL lol_latency: state %0d 2 edges after drop want 3", state); end
        tick();
        asserts++; if (state !== 2'd0 || trg_rst !== 1'b1 || link_up !== 1'b0 || ena !== 1'b0) begin
            fails++; $display("FAIL lol_outputs: state %0d rst %b up %b ena %b want 0/1/0/0", state, trg_rst, link_up, ena);
        end
        asserts++; if (lol !== 8'd1) begin fails++; $display("FAIL lol_count1: got %0d want 1", lol); end
        for (int k = 0; k < 299; k++) begin
            n = 0;
            while (state === 2'd0 && n < 20) begin tick(); n++; end
            if (state === 2'd0) tmo++;
            pll_lock = 1'b0;
            tick();
            pll_lock = 1'b1;
            n = 0;
            while (state !== 2'd0 && n < 5) begin tick(); n++; end
            if (state !== 2'd0) tmo++;
        end
        asserts++; if (tmo != 0) begin fails++; $display("FAIL lol_loop_timeout: %0d timeouts want 0", tmo); end
        asserts++; if (lol !== 8'd255) begin fails++; $display("FAIL lol_saturate: got %0d want 255", lol); end
        n = 0;
        while (state === 2'd0 && n < 20) begin tick(); n++; end
        resetn = 1'b0;
        #2;
        asserts++; if (state !== 2'd0 || trg_rst !== 1'b1 || lol !== 8'd0) begin
            fails++; $display("FAIL async_reset: state %0d rst %b lol %0d want 0/1/0", state, trg_rst, lol);
        end
    endtask

    task automatic test_resync();
        bring_up();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        req_resync = 1'b1;
        tick();
        req_resync = 1'b0;
        asserts++; if (state !== 2'd0 || trg_rst !== 1'b1 || lol !== 8'd1) begin
            fails++; $display("FAIL resync_vs_lol: state %0d rst %b lol %0d want 0/1/1", state, trg_rst, lol);
        end
        wait_data();
        req_resync = 1'b1;
        tick();
        req_resync = 1'b0;
        asserts++; if (state !== 2'd1 || trg_rst !== 1'b1 || link_up !== 1'b0 || ena !== 1'b0) begin
            fails++; $display("FAIL resync_comma: state %0d rst %b up %b ena %b want 1/1/0/0", state, trg_rst, link_up, ena);
        end
        asserts++; if (lol !== 8'd1) begin fails++; $display("FAIL resync_lol_hold: got %0d want 1", lol); end
    endtask

    task automatic test_force_prbs();
        logic exp_ena = 1'b0;
        int bad = 0;
        bring_up();
        for (int i = 0; i < 16; i++) begin
            force_prbs = i[1];
            tick();
            if (sel_at_edge === 1'b0) exp_ena = force_prbs;
            asserts++;
            if (ena !== exp_ena) begin
                fails++; bad++;
                $display("FAIL force_prbs[%0d]: ENA_TEST_PAT %b want %b (TX_SEL at edge %b)", i, ena, exp_ena, sel_at_edge);
            end
        end
        force_prbs = 1'b0;
    endtask

    task automatic test_uptime();
        bring_up();
        asserts++; if (uptime !== 32'd0) begin fails++; $display("FAIL uptime_entry: got %0d want 0", uptime); end
        for (int k = 1; k <= 5; k++) begin
            tick();
`ifdef GEM_TX_UPTIME_EN
            asserts++; if (uptime !== 32'(k)) begin fails++; $display("FAIL uptime_count: got %0d want %0d", uptime, k); end
`else
            asserts++; if (uptime !== 32'd0) begin fails++; $display("FAIL uptime_off: got %0d want 0", uptime); end
`endif
        end
        req_resync = 1'b1;
        tick();
        req_resync = 1'b0;
        asserts++; if (uptime !== 32'd0 || state !== 2'd1) begin
            fails++; $display("FAIL uptime_clear: uptime %0d state %0d want 0/1", uptime, state);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_no_prbs();
        test_loss_of_lock();
        test_resync();
        test_force_prbs();
        test_uptime();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
